// File: rtl/tiny_alu_pkg.sv
// Shared opcode definitions for the tiny ALU requester and its command buffer.
package tiny_alu_pkg;

    localparam int OPCODE_BITS = 3;

    typedef enum logic [OPCODE_BITS-1:0] {
        NO_OP = 3'd0,
        ADD   = 3'd1,
        AND   = 3'd2,
        XOR   = 3'd3,
        MUL   = 3'd4
    } opcode_e;

    // NO_OP is answered locally; every other opcode is sent to the ALU.
    function automatic logic needs_alu(input opcode_e op);
        return op != NO_OP;
    endfunction

endpackage

// File: rtl/tiny_alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so full and
// empty can be told apart when the index bits match.
module tiny_alu_cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic              push_ok;
    logic              pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                     (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);

    // A full buffer refuses writes even if a pop happens in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign pop_data_o = mem_q[rd_ptr_q[PTR_BITS-1:0]];

    // Next pointer values; the extra MSB makes wrap-around free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers, cleared to the empty state on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless while empty so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PTR_BITS-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/tiny_alu_requester.sv
// Buffers ALU commands, issues them one at a time to an external ALU with a
// start/done handshake, and returns each result (or a timeout) in order.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no command in flight; pops the buffer head when one is waiting
// ISSUE   | start held high with stable operands, waiting for done or expiry
// RESPOND | response presented until the consumer takes it
module tiny_alu_requester
    import tiny_alu_pkg::*;
#(
    parameter int INPUT_DATA_BITS = 8,
    parameter int CMD_FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [INPUT_DATA_BITS-1:0]   cmd_a_i,
    input  logic [INPUT_DATA_BITS-1:0]   cmd_b_i,
    input  logic [OPCODE_BITS-1:0]       cmd_opcode_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [2*INPUT_DATA_BITS-1:0] rsp_result_o,
    output logic                         rsp_timeout_o,
    output logic [INPUT_DATA_BITS-1:0]   alu_a_o,
    output logic [INPUT_DATA_BITS-1:0]   alu_b_o,
    output logic [OPCODE_BITS-1:0]       alu_opcode_o,
    output logic                         alu_start_o,
    input  logic [2*INPUT_DATA_BITS-1:0] alu_result_i,
    input  logic                         alu_done_i,
    output logic                         busy_o
);

    localparam int W        = INPUT_DATA_BITS;
    localparam int CMD_W    = 2 * W + OPCODE_BITS;
    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [CNT_BITS-1:0]  cnt_inc;
    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;
    opcode_e              op_q, op_d;
    logic [2*W-1:0]       result_q, result_d;
    logic                 timeout_q, timeout_d;

    logic [CMD_W-1:0]     fifo_wr_data;
    logic [CMD_W-1:0]     fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [W-1:0]         head_a;
    logic [W-1:0]         head_b;
    opcode_e              head_op;

    assign fifo_wr_data = {cmd_opcode_i, cmd_a_i, cmd_b_i};

    tiny_alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (cmd_valid_i),
        .push_data_i (fifo_wr_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head_b  = fifo_rd_data[W-1:0];
    assign head_a  = fifo_rd_data[2*W-1:W];
    assign head_op = opcode_e'(fifo_rd_data[CMD_W-1:2*W]);

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state logic: pop in IDLE, wait for done or expiry in ISSUE,
    // hold the response in RESPOND until it is consumed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    a_d      = head_a;
                    b_d      = head_b;
                    op_d     = head_op;
                    cnt_d    = '0;
                    if (needs_alu(head_op)) begin
                        state_d = ISSUE;
                    end else begin
                        result_d  = '0;
                        timeout_d = 1'b0;
                        state_d   = RESPOND;
                    end
                end
            end
            ISSUE: begin
                // done takes priority over an expiry in the same cycle
                if (alu_done_i) begin
                    result_d  = alu_result_i;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = RESPOND;
                end else if (cnt_inc == CNT_BITS'(TIMEOUT_CYCLES)) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = RESPOND;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESPOND: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, operand and response registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= NO_OP;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    assign cmd_ready_o   = !fifo_full;
    assign alu_start_o   = (state_q == ISSUE);
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_opcode_o  = op_q;
    assign rsp_valid_o   = (state_q == RESPOND);
    assign rsp_result_o  = result_q;
    assign rsp_timeout_o = timeout_q;
    assign busy_o        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_tiny_alu_requester.sv
// Scoreboard bench: stimulus pushes expected responses, a behavioural ALU
// answers start pulses, and a monitor checks responses as they leave.
module tb_tiny_alu_requester;
    import tiny_alu_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [W-1:0]     cmd_a_i, cmd_b_i;
    logic [2:0]       cmd_opcode_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [2*W-1:0]   rsp_result_o;
    logic             rsp_timeout_o;
    logic [W-1:0]     alu_a_o, alu_b_o;
    logic [2:0]       alu_opcode_o;
    logic             alu_start_o;
    logic [2*W-1:0]   alu_result_i;
    logic             alu_done_i;
    logic             busy_o;

    tiny_alu_requester #(
        .INPUT_DATA_BITS (W),
        .CMD_FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_a_i       (cmd_a_i),
        .cmd_b_i       (cmd_b_i),
        .cmd_opcode_i  (cmd_opcode_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_result_o  (rsp_result_o),
        .rsp_timeout_o (rsp_timeout_o),
        .alu_a_o       (alu_a_o),
        .alu_b_o       (alu_b_o),
        .alu_opcode_o  (alu_opcode_o),
        .alu_start_o   (alu_start_o),
        .alu_result_i  (alu_result_i),
        .alu_done_i    (alu_done_i),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        int           lat;
    } issue_t;

    typedef struct {
        logic [2*W-1:0] result;
        logic           timeout;
    } rsp_t;

    issue_t iss_q[$];
    rsp_t   exp_q[$];

    int  tests_run    = 0;
    int  tests_failed = 0;
    bit  spurious_en  = 1'b0;
    bit  rand_ready   = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: event not expected", name);
    endfunction

    // Reference arithmetic, operands zero-extended to the result width.
    function automatic logic [2*W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] xa, xb;
        xa = (2*W)'(a);
        xb = (2*W)'(b);
        case (opcode_e'(op))
            ADD:     return xa + xb;
            AND:     return xa & xb;
            XOR:     return xa ^ xb;
            MUL:     return xa * xb;
            default: return '0;
        endcase
    endfunction

    // lat = ISSUE cycle index at which the ALU raises done; 0 means never.
    // Done must land within the TMO cycles the request waits.
    function automatic void push_expect(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] op, input int lat);
        issue_t it;
        rsp_t   r;
        if (op == 3'(NO_OP)) begin
            r.result  = '0;
            r.timeout = 1'b0;
        end else begin
            it.a = a; it.b = b; it.op = op; it.lat = lat;
            iss_q.push_back(it);
            if (lat >= 1 && lat < TMO) begin
                r.result  = ref_op(op, a, b);
                r.timeout = 1'b0;
            end else begin
                r.result  = '0;
                r.timeout = 1'b1;
            end
        end
        exp_q.push_back(r);
    endfunction

    // Offer one command; call at posedge+1, returns at posedge+1 with valid still high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input int lat, input int max_wait, output bit ok);
        ok = 1'b0;
        cmd_a_i = a; cmd_b_i = b; cmd_opcode_i = op; cmd_valid_i = 1'b1;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk_i);
            if (cmd_ready_o) begin
                push_expect(a, b, op, lat);
                ok = 1'b1;
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < max_cycles && !reached; i++) begin
            @(posedge clk_i); #1;
            if (exp_q.size() == 0 && !busy_o) reached = 1'b1;
        end
        check("drain_to_idle", 32'(reached), 32'd1);
    endtask

    // Behavioural ALU: done in the lat-th start cycle, checks operands and start length.
    initial begin : alu_model
        issue_t cur;
        bit     active;
        int     k;
        int     dur;
        active = 1'b0;
        k = 0;
        cur.a = '0; cur.b = '0; cur.op = '0; cur.lat = 0;
        alu_done_i   = 1'b0;
        alu_result_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (!rst_n_i) begin
                active     = 1'b0;
                alu_done_i = 1'b0;
            end else if (alu_start_o) begin
                if (!active) begin
                    if (iss_q.size() == 0) begin
                        fail_now("unexpected_start");
                        cur.a = alu_a_o; cur.b = alu_b_o; cur.op = alu_opcode_o; cur.lat = 0;
                    end else begin
                        cur = iss_q.pop_front();
                    end
                    active = 1'b1;
                    k = 0;
                end else begin
                    k++;
                end
                check("alu_a_stable", 32'(alu_a_o), 32'(cur.a));
                check("alu_b_stable", 32'(alu_b_o), 32'(cur.b));
                check("alu_op_stable", 32'(alu_opcode_o), 32'(cur.op));
                alu_done_i   = (cur.lat != 0) && (k == cur.lat);
                alu_result_i = alu_done_i ? ref_op(cur.op, cur.a, cur.b) : (2*W)'($urandom);
            end else begin
                if (active) begin
                    dur = (cur.lat >= 1 && cur.lat < TMO) ? cur.lat + 1 : TMO;
                    check("start_length", 32'(k + 1), 32'(dur));
                    active = 1'b0;
                end
                alu_done_i   = spurious_en && ($urandom_range(0, 3) == 0);
                alu_result_i = (2*W)'($urandom);
            end
        end
    end

    // Response monitor: pops the scoreboard on every handshake.
    initial begin : monitor
        rsp_t           e;
        bit             holding;
        logic [2*W-1:0] held_res;
        logic           held_to;
        holding  = 1'b0;
        held_res = '0;
        held_to  = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                holding = 1'b0;
            end else if (rsp_valid_o) begin
                if (!holding) begin
                    held_res = rsp_result_o;
                    held_to  = rsp_timeout_o;
                    holding  = 1'b1;
                end
                if (rsp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_response");
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_result", 32'(rsp_result_o), 32'(e.result));
                        check("rsp_timeout", 32'(rsp_timeout_o), 32'(e.timeout));
                        check("rsp_stable", 32'({rsp_timeout_o, rsp_result_o}), 32'({held_to, held_res}));
                    end
                    holding = 1'b0;
                end
            end
        end
    end

    // Random back-pressure on the response side when enabled.
    initial begin : ready_driver
        forever begin
            @(posedge clk_i); #1;
            if (rand_ready) rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit ok;
        int seen;
        int r;
        int lat;
        logic [W-1:0] a, b;
        logic [2:0]   op;

        rst_n_i = 1'b0;
        cmd_valid_i = 1'b0; cmd_a_i = '0; cmd_b_i = '0; cmd_opcode_i = '0;
        rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_start", 32'(alu_start_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_result", 32'(rsp_result_o), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout_o), 32'd0);
        check("rst_alu_a", 32'(alu_a_o), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode_o), 32'd0);
        @(negedge clk_i) rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // ADD 5+3 with a one-cycle ALU: minimum latency profile
        send(8'h05, 8'h03, 3'(ADD), 1, 4, ok);
        cmd_valid_i = 1'b0;
        check("add_accepted", 32'(ok), 32'd1);
        check("lat_n_start", 32'(alu_start_o), 32'd0);
        @(posedge clk_i); #1;
        check("lat_n1_start", 32'(alu_start_o), 32'd1);
        check("lat_n1_rsp_valid", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i); #1;
        check("lat_n2_start", 32'(alu_start_o), 32'd1);
        @(posedge clk_i); #1;
        check("lat_n3_start", 32'(alu_start_o), 32'd0);
        check("lat_n3_rsp_valid", 32'(rsp_valid_o), 32'd1);
        wait_idle(100);

        // Directed corner cases: MUL FFxFF, NO_OP, never-done, done at expiry, done too late
        send(8'hFF, 8'hFF, 3'(MUL), 3, 4, ok);   cmd_valid_i = 1'b0; wait_idle(100);
        send(8'h12, 8'h34, 3'(NO_OP), 0, 4, ok); cmd_valid_i = 1'b0; wait_idle(100);
        send(8'h0A, 8'h0B, 3'(ADD), 0, 4, ok);   cmd_valid_i = 1'b0; wait_idle(100);
        send(8'hC3, 8'h5A, 3'(XOR), 15, 4, ok);  cmd_valid_i = 1'b0; wait_idle(100);
        send(8'hF0, 8'h3C, 3'(AND), 16, 4, ok);  cmd_valid_i = 1'b0; wait_idle(100);

        // Back-to-back with consumer stalled: one in flight plus DEPTH buffered
        rsp_ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(W'(i + 1), W'(i + 7), 3'(ADD), 2, 3, ok);
            check("b2b_accept", 32'(ok), 32'd1);
        end
        send(8'h99, 8'h01, 3'(ADD), 2, 6, ok);
        cmd_valid_i = 1'b0;
        check("b2b_full_reject", 32'(ok), 32'd0);
        check("b2b_cmd_ready_low", 32'(cmd_ready_o), 32'd0);
        check("b2b_busy", 32'(busy_o), 32'd1);
        rsp_ready_i = 1'b1;
        wait_idle(300);

        // Reset in the middle of a MUL with a second command buffered
        send(8'hFF, 8'hFE, 3'(MUL), 10, 4, ok);
        send(8'h01, 8'h01, 3'(ADD), 1, 4, ok);
        cmd_valid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (alu_start_o) seen = 1;
            else begin @(posedge clk_i); #1; end
        end
        check("rst_mid_saw_start", 32'(seen), 32'd1);
        repeat (2) @(posedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        check("rst_mid_start", 32'(alu_start_o), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_mid_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_alu_a", 32'(alu_a_o), 32'd0);
        check("rst_mid_alu_opcode", 32'(alu_opcode_o), 32'd0);
        check("rst_mid_rsp_result", 32'(rsp_result_o), 32'd0);
        exp_q.delete();
        iss_q.delete();
        @(negedge clk_i);
        @(negedge clk_i) rst_n_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i); #1;
            if (alu_start_o || rsp_valid_o) seen++;
        end
        check("post_reset_quiet", 32'(seen), 32'd0);
        check("post_reset_busy", 32'(busy_o), 32'd0);

        // Randomised traffic with back-pressure and stray done pulses
        spurious_en = 1'b1;
        rand_ready  = 1'b1;
        for (int n = 0; n < 80; n++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            op = 3'($urandom_range(0, 4));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      lat = 0;
            else if (r == 1) lat = TMO - 1;
            else if (r == 2) lat = TMO;
            else             lat = int'($urandom_range(1, 5));
            send(a, b, op, lat, 400, ok);
            check("rand_accept", 32'(ok), 32'd1);
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid_i = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk_i);
                #1;
            end
        end
        cmd_valid_i = 1'b0;
        rand_ready  = 1'b0;
        rsp_ready_i = 1'b1;
        wait_idle(3000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tiny_alu_requester.md
TINY_ALU_REQUESTER -- requirements
Module: tiny_alu_requester

Interface
REQ-001 SHALL have parameter INPUT_DATA_BITS, default 8, operand width.
REQ-002 SHALL have parameter CMD_FIFO_DEPTH, default 4, command buffer entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles to wait for alu_done_i.
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
 clk_i  in  1  clock
 rst_n_i  in  1  asynchronous reset, active low
 cmd_valid_i  in  1  command offered
 cmd_ready_o  out  1  command buffer can accept
 cmd_a_i, cmd_b_i  in  INPUT_DATA_BITS each  operands
 cmd_opcode_i  in  OPCODE_BITS  operation
 rsp_valid_o  out  1  response available
 rsp_ready_i  in  1  response consumed
 rsp_result_o  out  2*INPUT_DATA_BITS  result
 rsp_timeout_o  out  1  response is a timeout
 alu_a_o, alu_b_o  out  INPUT_DATA_BITS each  to ALU a_i/b_i
 alu_opcode_o  out  OPCODE_BITS  to ALU opcode_i
 alu_start_o  out  1  to ALU start_i
 alu_result_i  in  2*INPUT_DATA_BITS  from ALU result_o
 alu_done_i  in  1  from ALU done_o
 busy_o  out  1  FSM not in IDLE or buffer non-empty

Function
REQ-005 Command transfer SHALL occur on a rising edge with cmd_valid_i && cmd_ready_o; cmd_ready_o SHALL be 1 exactly when the buffer is not full, independent of cmd_valid_i.
REQ-006 Commands SHALL be issued to the ALU in acceptance order; one command in flight at most.
REQ-007 FSM states: IDLE, ISSUE, RESPOND.
REQ-008 IDLE: buffer non-empty -> pop head; opcode NO_OP -> RESPOND with result 0, timeout 0, no start pulse; otherwise -> ISSUE.
REQ-009 ISSUE: alu_start_o=1, alu_a_o/alu_b_o/alu_opcode_o held stable at the popped command for the whole state.
REQ-010 ISSUE: alu_done_i=1 sampled -> capture alu_result_i, timeout 0, -> RESPOND; alu_start_o SHALL be 0 in the cycle after done is sampled.
REQ-011 ISSUE: cycle counter starts at 0 on entry; reaching TIMEOUT_CYCLES without done -> result 0, timeout 1, -> RESPOND.
REQ-012 RESPOND: rsp_valid_o=1, rsp_result_o/rsp_timeout_o stable until rsp_ready_i=1 sampled -> IDLE.
REQ-013 Minimum latency, 1-cycle ALU op: command accepted edge N, start high in cycle N+1, done in N+2, rsp_valid_o high in N+3.
REQ-014 alu_done_i outside ISSUE SHALL be ignored.
REQ-015 Simultaneous done and counter reaching TIMEOUT_CYCLES: done SHALL win (timeout 0).
REQ-016 Buffer full with cmd_valid_i high: no write, no overwrite; pop and push in the same cycle when not full SHALL both succeed.
REQ-017 Buffer pointers SHALL wrap modulo CMD_FIFO_DEPTH without loss.

Reset
REQ-018 On rst_n_i low, immediately: FSM IDLE, buffer empty, counter 0, alu_start_o 0, rsp_valid_o 0, rsp_timeout_o 0, rsp_result_o 0, alu_a_o/alu_b_o/alu_opcode_o 0 (NO_OP), cmd_ready_o 1, busy_o 0.
REQ-019 Reset during ISSUE or RESPOND SHALL discard the in-flight command and response without any further ALU or response activity.

Structure
REQ-020 Opcode enum (NO_OP, ADD, AND, XOR, MUL) and OPCODE_BITS SHALL live in tiny_alu_pkg; FSM state typedef SHALL be local to the module.
REQ-021 Command buffer SHALL be sub-module tiny_alu_cmd_fifo (synchronous FIFO, full/empty flags, same clock/reset).

Verification
REQ-022 ADD a=8'h05 b=8'h03, ALU done 1 cycle after start -> rsp_result_o=16'h0008, timeout 0, start high exactly 2 cycles.
REQ-023 MUL a=8'hFF b=8'hFF, done 3 cycles after start -> rsp_result_o=16'hFE01; operands stable throughout ISSUE.
REQ-024 Five back-to-back commands, rsp_ready_i low -> cmd_ready_o falls after 4 buffered beyond the in-flight one; responses then drain in order.
REQ-025 NO_OP command -> alu_start_o stays 0, response result 0, timeout 0.
REQ-026 ALU never asserts done -> after 16 ISSUE cycles start drops, response result 0, timeout 1; done arriving same cycle as expiry -> timeout 0.
REQ-027 Reset asserted mid-MUL -> alu_start_o 0 and rsp_valid_o 0 asynchronously, buffer empty, no response after release.
